sm_tdm_recv: RTL and testbench
==============================

// Module: sm_tdm_recv
// PURPOSE
//  Receive-side monitor for TDM packets in the surveillance module; counterpart of the TDM send monitor.
//  Observes 32-bit words read from an endpoint's TDM receive buffer: one size word, then payload words.
//  Reports source endpoint and length once per complete packet; flags malformed packets.
//  Keeps saturating per-endpoint good-packet counters, readable by index.
// PARAMETERS
//  MAX_LEN            8   max payload words per packet; size 0 or >MAX_LEN is an error
//  NUM_TDM_ENDPOINTS  4   number of TDM endpoints monitored
//  CNT_WIDTH          16  width of each per-endpoint packet counter
//  localparam MAX_WIDTH  = $clog2(MAX_LEN+1); ENDP_WIDTH = $clog2(NUM_TDM_ENDPOINTS)
// PORTS
//  clk        in   1           clock; single clock domain
//  rst        in   1           synchronous, active-high reset
//  enable     in   1           data/ep hold a word transferred this cycle
//  data       in   32          observed word; size field is data[MAX_WIDTH-1:0]
//  ep         in   ENDP_WIDTH  endpoint the word was read from
//  src        out  ENDP_WIDTH  endpoint of last completed packet (valid with valid)
//  len        out  MAX_WIDTH   payload length of last completed packet
//  valid      out  1           one-cycle pulse: packet completed without error
//  error      out  1           one-cycle pulse: malformed packet detected
//  cnt_sel    in   ENDP_WIDTH  counter read index
//  cnt_clr    in   1           clear all counters
//  cnt_out    out  CNT_WIDTH   good-packet count of endpoint cnt_sel (combinational read)
// BEHAVIOUR
//  - Reset: state=SIZE, remaining=0, cur_ep=0, cur_len=0; src=0, len=0, valid=0, error=0; all counters 0.
//  - Reset mid-packet discards the packet: no valid, no error pulse.
//  - Cycles with enable=0 change nothing; gaps between words of a packet are legal.
//  - FSM states SIZE, RECV. All transitions only on enable=1.
//  - SIZE: s=data[MAX_WIDTH-1:0]; bits above MAX_WIDTH ignored.
//    - s==0 or s>MAX_LEN: error=1 next cycle; stay SIZE.
//    - else: cur_ep<=ep, cur_len<=s, remaining<=s; ->RECV.
//  - RECV, ep==cur_ep: remaining<=remaining-1.
//    - If remaining==1 (last word): ->SIZE; next cycle valid=1, src=cur_ep, len=cur_len;
//      counter[cur_ep] incremented the same edge valid rises.
//  - RECV, ep!=cur_ep: interleave error. error=1 next cycle; ->SIZE.
//    - Offending word is discarded, not taken as a new size word.
//  - valid and error never both high. Both are registered: latency 1 cycle after the deciding word.
//  - src/len hold their value until the next valid.
//  - Counters saturate at 2^CNT_WIDTH-1; no wrap.
//  - cnt_clr zeroes all counters next cycle and has priority over a same-cycle increment
//    (that packet is not counted; valid still pulses).
//  - cnt_sel >= NUM_TDM_ENDPOINTS reads 0.
// STRUCTURE
//  - Shared package sm_pkg: typedef enum logic {SM_TDM_SIZE, SM_TDM_RECV} sm_tdm_state_t.
//    The send monitor uses the same encoding.
//  - Sub-module sm_pkt_counter: NUM x CNT_WIDTH saturating counter bank with inc, inc_idx, clr,
//    rd_idx and rd_data ports.
//  - Top level holds the FSM, the remaining/cur_ep/cur_len registers and the output registers.
// TESTING
//  1 rst, enable ep=2: size 3, then 3 payload words -> valid 1 cycle after 3rd payload word;
//    src=2, len=3; cnt_sel=2 reads 1.
//  2 ep=1 size 0, then size 9 (MAX_LEN=8) -> two error pulses; no valid; FSM stays SIZE;
//    counters unchanged.
//  3 ep=0 size 4; after 2 payload words a word on ep=3 -> error; next word on ep=3 is parsed
//    as a size word.
//  4 size 2 on ep=1 with enable low 5 cycles between payload words -> valid timing is
//    1 cycle after the last word; src=1, len=2.
//  5 CNT_WIDTH=2: 5 good packets on ep=3 -> cnt_out saturates at 3.
//    cnt_clr on the same cycle as the 6th increment -> count reads 0.
//  6 rst asserted after size word + 1 payload word -> outputs and counters 0;
//    next word is parsed as a size word.

Source files
------------

// File: rtl/sm_pkg.sv
// Shared definitions for the surveillance-module TDM send/receive monitors.
// Both monitors use this state encoding so debug views line up.
package sm_pkg;

  typedef enum logic {
    SM_TDM_SIZE = 1'b0,
    SM_TDM_RECV = 1'b1
  } sm_tdm_state_t;

endpackage

// File: rtl/sm_pkt_counter.sv
// Bank of saturating per-endpoint packet counters.
// Provides a synchronous clear and a combinational indexed read.
module sm_pkt_counter #(
  parameter int NUM       = 4,
  parameter int CNT_WIDTH = 16,
  parameter int IDX_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic [IDX_WIDTH-1:0] inc_idx,
  input  logic                 clr,
  input  logic [IDX_WIDTH-1:0] rd_idx,
  output logic [CNT_WIDTH-1:0] rd_data
);

  localparam logic [IDX_WIDTH:0] NUM_W = NUM[IDX_WIDTH:0];

  logic [CNT_WIDTH-1:0] r_cnt [NUM];

  // Clear wins over a same-cycle increment; a full counter holds at all-ones.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM; i++) begin
      if (rst || clr) begin
        r_cnt[i] <= '0;
      end else if (inc && (inc_idx == i[IDX_WIDTH-1:0]) && (r_cnt[i] != '1)) begin
        r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_idx} < NUM_W) begin
      rd_data = r_cnt[rd_idx];
    end
  end

endmodule

// File: rtl/sm_tdm_recv.sv
// Receive-side TDM packet monitor: parses size + payload words per endpoint,
// pulses valid/error per packet and keeps per-endpoint good-packet counts.
module sm_tdm_recv
  import sm_pkg::*;
#(
  parameter  int MAX_LEN           = 8,
  parameter  int NUM_TDM_ENDPOINTS = 4,
  parameter  int CNT_WIDTH         = 16,
  localparam int MAX_WIDTH         = $clog2(MAX_LEN + 1),
  localparam int ENDP_WIDTH        = $clog2(NUM_TDM_ENDPOINTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  // enable qualifies data/ep for one transfer; there is no backpressure.
  input  logic                  enable,
  input  logic [31:0]           data,
  input  logic [ENDP_WIDTH-1:0] ep,
  output logic [ENDP_WIDTH-1:0] src,
  output logic [MAX_WIDTH-1:0]  len,
  output logic                  valid,
  output logic                  error,
  input  logic [ENDP_WIDTH-1:0] cnt_sel,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  cnt_out,
  output logic                  dbg_state
);

  localparam logic [MAX_WIDTH-1:0] MAX_LEN_W = MAX_LEN[MAX_WIDTH-1:0];

  sm_tdm_state_t         r_state, w_state_nxt;
  logic [MAX_WIDTH-1:0]  r_remaining, w_remaining_nxt;
  logic [ENDP_WIDTH-1:0] r_cur_ep, w_cur_ep_nxt;
  logic [MAX_WIDTH-1:0]  r_cur_len, w_cur_len_nxt;
  logic [ENDP_WIDTH-1:0] r_src;
  logic [MAX_WIDTH-1:0]  r_len;
  logic                  r_valid, r_error;
  logic                  w_valid_nxt, w_error_nxt;
  logic [MAX_WIDTH-1:0]  w_size;
  logic                  w_size_bad;

  assign w_size     = data[MAX_WIDTH-1:0];
  assign w_size_bad = (w_size == '0) || (w_size > MAX_LEN_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SM_TDM_SIZE;
      r_remaining <= '0;
      r_cur_ep    <= '0;
      r_cur_len   <= '0;
      r_src       <= '0;
      r_len       <= '0;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_cur_ep    <= w_cur_ep_nxt;
      r_cur_len   <= w_cur_len_nxt;
      r_valid     <= w_valid_nxt;
      r_error     <= w_error_nxt;
      if (w_valid_nxt) begin
        r_src <= r_cur_ep;
        r_len <= r_cur_len;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_cur_ep_nxt    = r_cur_ep;
    w_cur_len_nxt   = r_cur_len;
    w_valid_nxt     = 1'b0;
    w_error_nxt     = 1'b0;
    if (enable) begin
      case (r_state)
        SM_TDM_SIZE: begin
          if (w_size_bad) begin
            w_error_nxt = 1'b1;
          end else begin
            w_cur_ep_nxt    = ep;
            w_cur_len_nxt   = w_size;
            w_remaining_nxt = w_size;
            w_state_nxt     = SM_TDM_RECV;
          end
        end
        SM_TDM_RECV: begin
          if (ep == r_cur_ep) begin
            w_remaining_nxt = r_remaining - 1'b1;
            if (r_remaining == 1) begin
              w_valid_nxt = 1'b1;
              w_state_nxt = SM_TDM_SIZE;
            end
          end else begin
            // Interleaved word is dropped; the next word starts a new packet.
            w_error_nxt = 1'b1;
            w_state_nxt = SM_TDM_SIZE;
          end
        end
        default: w_state_nxt = SM_TDM_SIZE;
      endcase
    end
  end

  // Counter bumps on the same edge that raises valid.
  sm_pkt_counter #(
    .NUM       (NUM_TDM_ENDPOINTS),
    .CNT_WIDTH (CNT_WIDTH),
    .IDX_WIDTH (ENDP_WIDTH)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (w_valid_nxt),
    .inc_idx (r_cur_ep),
    .clr     (cnt_clr),
    .rd_idx  (cnt_sel),
    .rd_data (cnt_out)
  );

  assign src       = r_src;
  assign len       = r_len;
  assign valid     = r_valid;
  assign error     = r_error;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sm_tdm_recv.sv
// Directed bench for sm_tdm_recv with hand-computed expectations.
// Uses CNT_WIDTH=2 so counter saturation is reachable in a few packets.
module tb_sm_tdm_recv;

  localparam int MAX_LEN   = 8;
  localparam int NUM_EP    = 4;
  localparam int CNT_WIDTH = 2;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] data;
  logic [1:0]  ep;
  logic [1:0]  src;
  logic [3:0]  len;
  logic        valid;
  logic        error;
  logic [1:0]  cnt_sel;
  logic        cnt_clr;
  logic [1:0]  cnt_out;
  logic        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  sm_tdm_recv #(
    .MAX_LEN           (MAX_LEN),
    .NUM_TDM_ENDPOINTS (NUM_EP),
    .CNT_WIDTH         (CNT_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .data      (data),
    .ep        (ep),
    .src       (src),
    .len       (len),
    .valid     (valid),
    .error     (error),
    .cnt_sel   (cnt_sel),
    .cnt_clr   (cnt_clr),
    .cnt_out   (cnt_out),
    .dbg_state (dbg_state)
  );

  // Clock and safety timeout.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers: inputs change on the falling edge, outputs are checked there too.
  task automatic put(input logic [1:0] e, input logic [31:0] d);
    @(negedge clk);
    enable = 1'b1;
    ep     = e;
    data   = d;
  endtask

  task automatic gap();
    @(negedge clk);
    enable = 1'b0;
    data   = $urandom;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic e);
    check({tag, "_valid"}, valid, v);
    check({tag, "_error"}, error, e);
  endtask

  task automatic chk_cnt(input string tag, input logic [1:0] sel, input logic [1:0] exp);
    cnt_sel = sel;
    #1;
    check(tag, cnt_out, exp);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; data = '0; ep = '0; cnt_sel = '0; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk_out("rst", 1'b0, 1'b0);
    check("rst_src", src, 0);
    check("rst_len", len, 0);
    check("rst_state", dbg_state, 0);
    for (int i = 0; i < NUM_EP; i++) chk_cnt("rst_cnt", i[1:0], 0);
    rst = 1'b0;

    // 1: good 3-word packet on ep 2
    put(2, 32'd3);
    put(2, $urandom);
    chk_out("t1_size", 1'b0, 1'b0);
    check("t1_state_recv", dbg_state, 1);
    put(2, $urandom);
    put(2, $urandom);
    chk_out("t1_mid", 1'b0, 1'b0);
    gap();
    chk_out("t1_done", 1'b1, 1'b0);
    check("t1_src", src, 2);
    check("t1_len", len, 3);
    chk_cnt("t1_cnt2", 2, 1);
    gap();
    chk_out("t1_after", 1'b0, 1'b0);
    check("t1_src_hold", src, 2);
    check("t1_len_hold", len, 3);

    // 2: size 0 then size 9 -> two errors, no packet
    put(1, 32'd0);
    gap();
    chk_out("t2_size0", 1'b0, 1'b1);
    check("t2_state0", dbg_state, 0);
    put(1, 32'd9);
    gap();
    chk_out("t2_size9", 1'b0, 1'b1);
    check("t2_state9", dbg_state, 0);
    gap();
    chk_out("t2_quiet", 1'b0, 1'b0);
    chk_cnt("t2_cnt1", 1, 0);
    chk_cnt("t2_cnt2", 2, 1);

    // 3: interleave error; offending ep then starts a fresh packet
    put(0, 32'd4);
    put(0, $urandom);
    put(0, $urandom);
    put(3, 32'd7);
    gap();
    chk_out("t3_ilv", 1'b0, 1'b1);
    check("t3_state", dbg_state, 0);
    put(3, 32'd1);
    gap();
    chk_out("t3_size", 1'b0, 1'b0);
    put(3, $urandom);
    gap();
    chk_out("t3_done", 1'b1, 1'b0);
    check("t3_src", src, 3);
    check("t3_len", len, 1);
    chk_cnt("t3_cnt0", 0, 0);
    chk_cnt("t3_cnt3", 3, 1);

    // 4: size 2 (upper bits set) with a 5-cycle gap between payload words
    put(1, 32'hABCD_0012);
    put(1, $urandom);
    for (int i = 0; i < 5; i++) begin
      gap();
      chk_out("t4_gap", 1'b0, 1'b0);
    end
    put(1, $urandom);
    gap();
    chk_out("t4_done", 1'b1, 1'b0);
    check("t4_src", src, 1);
    check("t4_len", len, 2);
    chk_cnt("t4_cnt1", 1, 1);

    // 5: ep 3 reaches 5 good packets (already 1) -> saturates at 3
    for (int i = 0; i < 4; i++) begin
      put(3, 32'd1);
      put(3, $urandom);
      gap();
      chk_out("t5_pkt", 1'b1, 1'b0);
      chk_cnt("t5_cnt3", 3, (i == 0) ? 2'd2 : 2'd3);
    end
    put(3, 32'd1);
    put(3, $urandom);
    cnt_clr = 1'b1;
    gap();
    cnt_clr = 1'b0;
    chk_out("t5_clr_pkt", 1'b1, 1'b0);
    chk_cnt("t5_clr_cnt3", 3, 0);
    chk_cnt("t5_clr_cnt1", 1, 0);
    chk_cnt("t5_clr_cnt2", 2, 0);

    // 6: reset mid-packet discards it
    put(2, 32'd1);
    put(2, $urandom);
    gap();
    chk_out("t6_pre", 1'b1, 1'b0);
    chk_cnt("t6_pre_cnt2", 2, 1);
    put(2, 32'd3);
    put(2, $urandom);
    @(negedge clk);
    enable = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_out("t6_rst", 1'b0, 1'b0);
    check("t6_src", src, 0);
    check("t6_len", len, 0);
    check("t6_state", dbg_state, 0);
    chk_cnt("t6_cnt2", 2, 0);
    gap();
    chk_out("t6_quiet", 1'b0, 1'b0);
    put(2, 32'd2);
    put(2, $urandom);
    put(2, $urandom);
    gap();
    chk_out("t6_done", 1'b1, 1'b0);
    check("t6_src2", src, 2);
    check("t6_len2", len, 2);
    chk_cnt("t6_cnt2b", 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
